// File: rtl/skinny_rc_sequencer_if.sv
// Start/advance handshake and constant batch bus between the round-constant
// sequencer (slave) and the unrolled round function that consumes it (master).
interface skinny_rc_sequencer_if #(
  parameter int unsigned RNDS_PER_CLK = 4
);
  logic                        start;
  logic                        dec;
  logic                        adv;
  logic [6*RNDS_PER_CLK-1:0]   constant;
  logic [5:0]                  batch_idx;
  logic                        valid;
  logic                        last;
  logic                        done;

  modport master (
    output start, dec, adv,
    input  constant, batch_idx, valid, last, done
  );

  modport slave (
    input  start, dec, adv,
    output constant, batch_idx, valid, last, done
  );
endinterface

// File: rtl/skinny_rc_sequencer.sv
// SKINNY round-constant sequencer: 6-bit LFSR seed emits RNDS_PER_CLK constants
// per batch, forward (encrypt) or reverse (decrypt) order.
module skinny_rc_sequencer #(
  parameter int unsigned RNDS_PER_CLK = 4,
  parameter int unsigned NUM_RNDS     = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  skinny_rc_sequencer_if.slave   bus
);
  localparam int unsigned LANE_W  = 6;
  localparam int unsigned IDX_W   = 6;
  localparam int unsigned CONST_W = LANE_W * RNDS_PER_CLK;
  localparam int unsigned BATCHES = NUM_RNDS / RNDS_PER_CLK;

  function automatic logic [LANE_W-1:0] lfsr_fwd(input logic [LANE_W-1:0] x);
    return {x[4:0], x[5] ^ x[4] ^ 1'b1};
  endfunction

  function automatic logic [LANE_W-1:0] lfsr_inv(input logic [LANE_W-1:0] x);
    return {x[0] ^ x[5] ^ 1'b1, x[5:1]};
  endfunction

  function automatic logic [LANE_W-1:0] fwd_pow(input logic [LANE_W-1:0] x,
                                                input int unsigned n);
    logic [LANE_W-1:0] y;
    y = x;
    for (int unsigned i = 0; i < n; i++) y = lfsr_fwd(y);
    return y;
  endfunction

  function automatic logic [LANE_W-1:0] inv_pow(input logic [LANE_W-1:0] x,
                                                input int unsigned n);
    logic [LANE_W-1:0] y;
    y = x;
    for (int unsigned i = 0; i < n; i++) y = lfsr_inv(y);
    return y;
  endfunction

  // Constant of the final round; seeds batch 0 of a reverse sequence.
  localparam logic [LANE_W-1:0] RC_LAST  = fwd_pow(LANE_W'(0), NUM_RNDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BATCHES - 1);

  if (RNDS_PER_CLK == 0 || RNDS_PER_CLK > NUM_RNDS) begin : g_bad_rpc
    $error("RNDS_PER_CLK must be in 1..NUM_RNDS");
  end
  if ((NUM_RNDS % RNDS_PER_CLK) != 0) begin : g_bad_div
    $error("NUM_RNDS must be a multiple of RNDS_PER_CLK");
  end
  if (BATCHES > (1 << IDX_W)) begin : g_bad_batches
    $error("batch count exceeds batch_idx range");
  end

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e             state_q, state_d;
  logic [LANE_W-1:0]  seed_q, seed_d;
  logic [IDX_W-1:0]   batch_q, batch_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;

  logic               valid;
  logic               is_last;
  logic [LANE_W-1:0]  seed_step;
  logic [CONST_W-1:0] lanes;

  assign valid   = (state_q == S_RUN);
  assign is_last = valid && (batch_q == LAST_IDX);

  // Lane values are pure functions of the seed; nothing per-round is stored.
  always_comb begin
    lanes = '0;
    for (int unsigned j = 0; j < RNDS_PER_CLK; j++) begin
      lanes[LANE_W*j +: LANE_W] = dir_q ? inv_pow(seed_q, j) : fwd_pow(seed_q, j + 1);
    end
    seed_step = dir_q ? inv_pow(seed_q, RNDS_PER_CLK) : fwd_pow(seed_q, RNDS_PER_CLK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      seed_q  <= '0;
      batch_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      batch_q <= batch_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Start wins over advance; an aborted sequence never reports done.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    batch_d = batch_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (bus.start) begin
      state_d = S_RUN;
      batch_d = '0;
      dir_d   = bus.dec;
      seed_d  = bus.dec ? RC_LAST : LANE_W'(0);
    end else if (bus.adv && valid) begin
      if (is_last) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        batch_d = '0;
        seed_d  = '0;
      end else begin
        batch_d = batch_q + IDX_W'(1);
        seed_d  = seed_step;
      end
    end
  end

  assign bus.constant  = valid ? lanes : '0;
  assign bus.batch_idx = batch_q;
  assign bus.valid     = valid;
  assign bus.last      = is_last;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_skinny_rc_sequencer.sv
// Directed bench for skinny_rc_sequencer: R=1/N=40, R=4/N=40 and R=1/N=56
// instances checked against a hand-written SKINNY round-constant table.
module tb_skinny_rc_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  skinny_rc_sequencer_if #(.RNDS_PER_CLK(1)) if_a ();
  skinny_rc_sequencer_if #(.RNDS_PER_CLK(4)) if_b ();
  skinny_rc_sequencer_if #(.RNDS_PER_CLK(1)) if_c ();

  skinny_rc_sequencer #(.RNDS_PER_CLK(1), .NUM_RNDS(40)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  skinny_rc_sequencer #(.RNDS_PER_CLK(4), .NUM_RNDS(40)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  skinny_rc_sequencer #(.RNDS_PER_CLK(1), .NUM_RNDS(56)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  int n_vec = 0;
  int n_err = 0;
  int idx;
  logic [15:0] pat;

  logic [5:0] rc_tab [0:55] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
    6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A,
    6'h34, 6'h29, 6'h12, 6'h24, 6'h08, 6'h11, 6'h22, 6'h04, 6'h09, 6'h13,
    6'h26, 6'h0C, 6'h19, 6'h32, 6'h25, 6'h0A
  };

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Expected 4-lane batch word for N=40; reverse batches start at round 39.
  function automatic logic [23:0] pack4(input int b, input int rev);
    logic [23:0] w;
    int r;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      r = (rev != 0) ? (39 - (4*b + j)) : (4*b + j);
      w = w | (24'(rc_tab[r]) << (6*j));
    end
    return w;
  endfunction

  initial begin
    {if_a.start, if_a.dec, if_a.adv} = 3'b000;
    {if_b.start, if_b.dec, if_b.adv} = 3'b000;
    {if_c.start, if_c.dec, if_c.adv} = 3'b000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_eq("rst_valid_a", 32'(if_a.valid), 0);
    check_eq("rst_const_a", 32'(if_a.constant), 0);
    check_eq("rst_done_b", 32'(if_b.done), 0);
    check_eq("rst_idx_b", 32'(if_b.batch_idx), 0);
    check_eq("rst_last_c", 32'(if_c.last), 0);

    // R=1 forward with adv held high
    if_a.start = 1'b1; if_a.dec = 1'b0;
    @(negedge clk);
    if_a.start = 1'b0; if_a.adv = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check_eq($sformatf("fwd1_rc%0d", k), 32'(if_a.constant), 32'(rc_tab[k]));
      check_eq($sformatf("fwd1_idx%0d", k), 32'(if_a.batch_idx), 32'(k));
      check_eq($sformatf("fwd1_last%0d", k), 32'(if_a.last), 32'(k == 39));
      check_eq($sformatf("fwd1_done%0d", k), 32'(if_a.done), 0);
      @(negedge clk);
    end
    if_a.adv = 1'b0;
    check_eq("fwd1_done_pulse", 32'(if_a.done), 1);
    check_eq("fwd1_valid_end", 32'(if_a.valid), 0);
    check_eq("fwd1_const_end", 32'(if_a.constant), 0);
    @(negedge clk);
    check_eq("fwd1_done_clear", 32'(if_a.done), 0);

    // R=1 reverse
    if_a.start = 1'b1; if_a.dec = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0; if_a.dec = 1'b0; if_a.adv = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check_eq($sformatf("rev1_rc%0d", k), 32'(if_a.constant), 32'(rc_tab[39-k]));
      check_eq($sformatf("rev1_last%0d", k), 32'(if_a.last), 32'(k == 39));
      @(negedge clk);
    end
    if_a.adv = 1'b0;
    check_eq("rev1_done_pulse", 32'(if_a.done), 1);
    @(negedge clk);

    // R=4 both directions, one stall cycle on batch 0
    for (int d = 0; d < 2; d++) begin
      if_b.start = 1'b1; if_b.dec = 1'(d);
      @(negedge clk);
      if_b.start = 1'b0; if_b.dec = 1'b0;
      if (d == 0) check_eq("r4_b0_literal", 32'(if_b.constant), 32'h003C70C1);
      @(negedge clk);
      check_eq($sformatf("r4_stall_d%0d", d), 32'(if_b.constant), 32'(pack4(0, d)));
      if_b.adv = 1'b1;
      for (int k = 0; k < 10; k++) begin
        check_eq($sformatf("r4_d%0d_b%0d", d, k), 32'(if_b.constant), 32'(pack4(k, d)));
        check_eq($sformatf("r4_d%0d_idx%0d", d, k), 32'(if_b.batch_idx), 32'(k));
        check_eq($sformatf("r4_d%0d_last%0d", d, k), 32'(if_b.last), 32'(k == 9));
        if (d == 0 && k == 1) check_eq("r4_b1_literal", 32'(if_b.constant), 32'h00EFDF9F);
        @(negedge clk);
      end
      if_b.adv = 1'b0;
      check_eq($sformatf("r4_d%0d_done", d), 32'(if_b.done), 1);
      check_eq($sformatf("r4_d%0d_valid_end", d), 32'(if_b.valid), 0);
      @(negedge clk);
    end

    // R=1, N=56 forward
    if_c.start = 1'b1;
    @(negedge clk);
    if_c.start = 1'b0; if_c.adv = 1'b1;
    for (int k = 0; k < 56; k++) begin
      check_eq($sformatf("n56_rc%0d", k), 32'(if_c.constant), 32'(rc_tab[k]));
      check_eq($sformatf("n56_last%0d", k), 32'(if_c.last), 32'(k == 55));
      @(negedge clk);
    end
    if_c.adv = 1'b0;
    check_eq("n56_done", 32'(if_c.done), 1);
    @(negedge clk);

    // Stalls, then restart at batch 5
    pat = 16'b0110_1001_1100_0101;
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    idx = 0;
    for (int i = 0; i < 16 && idx < 5; i++) begin
      check_eq($sformatf("stall_rc%0d", i), 32'(if_a.constant), 32'(rc_tab[idx]));
      check_eq($sformatf("stall_idx%0d", i), 32'(if_a.batch_idx), 32'(idx));
      if_a.adv = pat[i];
      @(negedge clk);
      if (pat[i]) idx++;
    end
    if_a.adv = 1'b0;
    check_eq("stall_at5", 32'(if_a.batch_idx), 5);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    check_eq("restart_idx", 32'(if_a.batch_idx), 0);
    check_eq("restart_rc", 32'(if_a.constant), 32'h01);
    check_eq("restart_done", 32'(if_a.done), 0);

    // start together with adv on the last batch: restart, no done
    if_a.adv = 1'b1;
    repeat (39) @(negedge clk);
    check_eq("abort_last", 32'(if_a.last), 1);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0; if_a.adv = 1'b0;
    check_eq("abort_valid", 32'(if_a.valid), 1);
    check_eq("abort_idx", 32'(if_a.batch_idx), 0);
    check_eq("abort_done", 32'(if_a.done), 0);
    @(negedge clk);
    check_eq("abort_done2", 32'(if_a.done), 0);

    // start during the done cycle
    if_a.adv = 1'b1;
    repeat (40) @(negedge clk);
    if_a.adv = 1'b0;
    check_eq("dstart_done", 32'(if_a.done), 1);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    check_eq("dstart_valid", 32'(if_a.valid), 1);
    check_eq("dstart_rc", 32'(if_a.constant), 32'h01);
    check_eq("dstart_done_clear", 32'(if_a.done), 0);

    // reset mid-sequence
    if_a.adv = 1'b1;
    repeat (3) @(negedge clk);
    if_a.adv = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mrst_valid", 32'(if_a.valid), 0);
    check_eq("mrst_const", 32'(if_a.constant), 0);
    check_eq("mrst_done", 32'(if_a.done), 0);
    check_eq("mrst_idx", 32'(if_a.batch_idx), 0);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0; if_a.adv = 1'b1;
    check_eq("mrst_rc0", 32'(if_a.constant), 32'h01);
    @(negedge clk);
    if_a.adv = 1'b0;
    check_eq("mrst_rc1", 32'(if_a.constant), 32'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
